// File: rtl/ripple_capture_pkg.sv
// Shared constants and FSM state encoding for the ripple-counter capture stage.
package ripple_capture_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_nff.sv
// Single-bit SYNC_STAGES-deep synchronizer; output lags input by SYNC_STAGES edges.
module sync_nff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Synchronizes and debounces a 4-bit ripple count, extends it across wraps and presents
// each settled value on valid/ready; one-deep pending slot absorbs values during stalls.
module ripple_count_capture
  import ripple_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int EXT_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic [COUNT_W-1:0]           q_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [COUNT_W+EXT_WIDTH-1:0] out_count,
  output logic                         wrap_pulse,
  output logic                         overrun
);

  localparam int OUT_W = COUNT_W + EXT_WIDTH;
  localparam int RUN_W = $clog2(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_NEED = RUN_W'(STABLE_CYCLES - 2);

  logic [COUNT_W-1:0]   s;
  logic [COUNT_W-1:0]   s_prev_q, s_prev_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [COUNT_W-1:0]   last_stable_q, last_stable_d;
  logic [EXT_WIDTH-1:0] ext_q, ext_d;
  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_count_q, out_count_d;
  logic [OUT_W-1:0]     pending_q, pending_d;
  logic                 pending_vld_q, pending_vld_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic                 overrun_q, overrun_d;

  logic                 same;
  logic                 accept;
  logic                 is_wrap;
  logic [EXT_WIDTH-1:0] ext_next;
  logic [OUT_W-1:0]     acc_val;
  logic                 handshake;

  for (genvar i = 0; i < COUNT_W; i++) begin : g_sync
    sync_nff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (q_in[i]),
      .q     (s[i])
    );
  end

  // The current sample counts as the last of the STABLE_CYCLES equal edges once run_q
  // already holds STABLE_CYCLES-2 prior matches.
  assign same      = (s == s_prev_q);
  assign accept    = same && (run_q >= RUN_NEED) && (s != last_stable_q) && !clear;
  assign is_wrap   = (s < last_stable_q);
  assign ext_next  = is_wrap ? ext_q + EXT_WIDTH'(1) : ext_q;
  assign acc_val   = {ext_next, s};
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    s_prev_d      = s;
    run_d         = run_q;
    last_stable_d = last_stable_q;
    ext_d         = ext_q;
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_count_d   = out_count_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    wrap_pulse_d  = 1'b0;
    overrun_d     = overrun_q;

    if (!same) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end

    // Wrap tracking runs regardless of presentation state.
    if (accept) begin
      last_stable_d = s;
      ext_d         = ext_next;
      wrap_pulse_d  = is_wrap;
    end

    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (enable) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        out_valid_d = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end else if (accept) begin
          out_count_d = acc_val;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (pending_vld_q) begin
            out_count_d   = pending_q;
            out_valid_d   = 1'b1;
            pending_vld_d = 1'b0;
            if (accept) begin
              pending_d     = acc_val;
              pending_vld_d = 1'b1;
            end
          end else if (accept) begin
            out_count_d = acc_val;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = enable ? TRACK : IDLE;
          end
        end else if (accept) begin
          pending_d     = acc_val;
          pending_vld_d = 1'b1;
          overrun_d     = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    if (clear) begin
      ext_d         = '0;
      last_stable_d = '0;
      run_d         = '0;
      pending_d     = '0;
      pending_vld_d = 1'b0;
      overrun_d     = 1'b0;
      out_valid_d   = 1'b0;
      wrap_pulse_d  = 1'b0;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev_q      <= '0;
      run_q         <= '0;
      last_stable_q <= '0;
      ext_q         <= '0;
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_count_q   <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      wrap_pulse_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      s_prev_q      <= s_prev_d;
      run_q         <= run_d;
      last_stable_q <= last_stable_d;
      ext_q         <= ext_d;
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_count_q   <= out_count_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      wrap_pulse_q  <= wrap_pulse_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign wrap_pulse = wrap_pulse_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed vectors plus a randomized run against a history-window reference model.
module tb_ripple_count_capture;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       enable;
  logic [3:0] q_in;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_count;
  logic       wrap_pulse;
  logic       overrun;

  int tests;
  int fails;
  int wrap_cnt;

  ripple_count_capture dut (
    .clk        (clk),
    .reset      (rst_n),
    .clear      (clear),
    .enable     (enable),
    .q_in       (q_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .wrap_pulse (wrap_pulse),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Settle a value; acceptance must appear exactly four edges after the first sampling edge.
  task automatic step(input logic [3:0] v, input logic [7:0] exp, input logic exp_w,
                      input string nm);
    q_in = v;
    repeat (4) begin
      tick();
      wrap_cnt += int'(wrap_pulse);
      chk({nm, "_early_valid"}, out_valid, 0);
      chk({nm, "_early_wrap"}, wrap_pulse, 0);
    end
    tick();
    wrap_cnt += int'(wrap_pulse);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_count"}, out_count, exp);
    chk({nm, "_wrap"}, wrap_pulse, exp_w);
    if (out_ready) begin
      tick();
      wrap_cnt += int'(wrap_pulse);
      chk({nm, "_drain_valid"}, out_valid, 0);
      chk({nm, "_drain_wrap"}, wrap_pulse, 0);
    end
  endtask

  typedef struct {
    logic [3:0] q;
    logic [7:0] exp;
    logic       w;
  } vec_t;

  vec_t       tbl[4];
  logic [3:0] trans[4];
  int         hist[$];
  logic [3:0] mlast;
  logic [3:0] mext;
  int         seen8;

  initial begin
    tests = 0; fails = 0; wrap_cnt = 0;
    tbl[0] = '{q: 4'd14, exp: 8'h0E, w: 1'b0};
    tbl[1] = '{q: 4'd15, exp: 8'h0F, w: 1'b0};
    tbl[2] = '{q: 4'd0,  exp: 8'h10, w: 1'b1};
    tbl[3] = '{q: 4'd6,  exp: 8'h16, w: 1'b0};
    trans[0] = 4'd6; trans[1] = 4'd4; trans[2] = 4'd0; trans[3] = 4'd8;

    rst_n = 1'b1; clear = 1'b0; enable = 1'b0; out_ready = 1'b0; q_in = 4'd0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);

    // Clean step 0 -> 5 with consumer stalled
    enable = 1'b1;
    tick(); tick();
    step(4'd5, 8'h05, 1'b0, "clean");
    repeat (3) begin
      tick();
      chk("clean_hold_valid", out_valid, 1);
      chk("clean_hold_count", out_count, 8'h05);
    end
    out_ready = 1'b1;
    tick();
    chk("clean_hs_valid", out_valid, 0);

    // Return to zero (wrap), then clear to start the overrun case from ext=0
    q_in = 4'd0;
    repeat (8) tick();
    clear = 1'b1; tick(); clear = 1'b0;

    out_ready = 1'b0;
    step(4'd3, 8'h03, 1'b0, "ovr_first");
    for (int i = 0; i < 2; i++) begin
      q_in = (i == 0) ? 4'd4 : 4'd5;
      repeat (6) begin
        tick();
        chk("ovr_hold_valid", out_valid, 1);
        chk("ovr_hold_count", out_count, 8'h03);
      end
    end
    chk("ovr_flag", overrun, 1);
    out_ready = 1'b1;
    tick();
    chk("ovr_next_valid", out_valid, 1);
    chk("ovr_next_count", out_count, 8'h05);
    tick();
    chk("ovr_drain_valid", out_valid, 0);

    // Ripple transient 7 -> 6 -> 4 -> 0 -> 8
    step(4'd7, 8'h07, 1'b0, "trans_base");
    seen8 = 0;
    for (int i = 0; i < 4; i++) begin
      q_in = trans[i];
      repeat ((i == 3) ? 10 : 1) begin
        tick();
        chk("trans_wrap", wrap_pulse, 0);
        if (out_valid) begin
          chk("trans_count", out_count, 8'h08);
          seen8++;
        end
      end
    end
    chk("trans_seen8", seen8, 1);

    // Wrap table
    wrap_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].q, tbl[i].exp, tbl[i].w, $sformatf("tbl%0d", i));
    end
    chk("tbl_wrap_total", wrap_cnt, 1);

    // Clear during HOLD with ext=2
    out_ready = 1'b0;
    step(4'd2, 8'h22, 1'b1, "clr_hold");
    q_in = 4'd3;
    repeat (5) tick();
    chk("clr_pre_overrun", overrun, 1);
    enable = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_overrun", overrun, 0);
    repeat (6) begin
      tick();
      chk("clr_idle_valid", out_valid, 0);
    end
    enable = 1'b1;
    tick();
    step(4'd9, 8'h09, 1'b0, "clr_after");
    out_ready = 1'b1;
    tick();
    chk("clr_after_hs", out_valid, 0);

    // Randomized run against a sliding-window model
    q_in = 4'd0;
    repeat (8) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (5) tick();
    hist = {0, 0, 0, 0};
    mlast = 4'd0; mext = 4'd0;
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      len = (seg == 59) ? 8 : int'($urandom_range(1, 6));
      q_in = 4'($urandom_range(0, 15));
      for (int c = 0; c < len; c++) begin
        int  n;
        logic acc;
        logic w;
        tick();
        hist.push_back(int'(q_in));
        n = hist.size() - 1;
        acc = (hist[n-2] == hist[n-3]) && (hist[n-3] == hist[n-4]) && (hist[n-2] != int'(mlast));
        w = 1'b0;
        if (acc) begin
          w = (hist[n-2] < int'(mlast));
          if (w) mext = mext + 4'd1;
          mlast = 4'(hist[n-2]);
        end
        chk("rand_valid", out_valid, acc);
        chk("rand_wrap", wrap_pulse, w);
        if (acc) chk("rand_count", out_count, {mext, mlast});
      end
    end

    // Asynchronous reset while holding a value with overrun set
    begin
      logic [3:0] v;
      logic       w;
      out_ready = 1'b0;
      v = mlast ^ 4'h8;
      w = (v < mlast);
      step(v, {w ? mext + 4'd1 : mext, v}, w, "arst_hold");
      q_in = v ^ 4'h1;
      repeat (6) tick();
      chk("arst_pre_overrun", overrun, 1);
      chk("arst_pre_valid", out_valid, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", out_count, 0);
    chk("arst_wrap", wrap_pulse, 0);
    chk("arst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_rel_valid", out_valid, 0);
    chk("arst_rel_count", out_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
